// File: rtl/hex_dump_tx_seq.sv
// Binary word to uppercase ASCII hex dumper feeding a UART Tx byte interface.
// Emits MSB nibble first, a separator between words, and CR/LF at line end or on flush.
module hex_dump_tx_seq #(
   parameter int          DATA_WIDTH     = 16,
   parameter int          WORDS_PER_LINE = 8,
   parameter logic [7:0]  SEP_CHAR       = 8'h20,
   localparam int         NCHAR          = DATA_WIDTH / 4,
   localparam int         CW             = $clog2(WORDS_PER_LINE + 1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] iDATA,
   input  logic                  iVALID,
   output logic                  oREADY,
   input  logic                  iFLUSH,
   output logic [7:0]            oTX_DATA,
   output logic                  oTX_VALID,
   input  logic                  iTX_READY,
   output logic                  oBUSY,
   output logic [CW-1:0]         oWORD_CNT
);

   localparam int IW = (NCHAR > 1) ? $clog2(NCHAR) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NCHAR - 1);
   localparam logic [CW-1:0] LINE_FULL = CW'(WORDS_PER_LINE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEX,
      S_SEP,
      S_CR,
      S_LF
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         word_cnt_q, word_cnt_d;
   logic                  flush_pend_q, flush_pend_d;

   logic [3:0]            nib;
   logic [7:0]            hex_char;
   logic [CW-1:0]         cnt_inc;
   logic                  flush_req;

   assign nib       = shift_q[DATA_WIDTH-1 -: 4];
   assign hex_char  = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
   assign cnt_inc   = word_cnt_q + CW'(1);
   // A flush arriving in the same cycle as the deciding handshake still counts.
   assign flush_req = flush_pend_q | iFLUSH;

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      idx_d        = idx_q;
      word_cnt_d   = word_cnt_q;
      flush_pend_d = flush_pend_q | (iFLUSH && (state_q != S_IDLE));
      oREADY       = 1'b0;
      oTX_VALID    = 1'b0;
      oTX_DATA     = 8'h00;

      case (state_q)
         S_IDLE: begin
            oREADY = 1'b1;
            if (iVALID) begin
               shift_d      = iDATA;
               idx_d        = '0;
               flush_pend_d = flush_req;
               state_d      = S_HEX;
            end else begin
               flush_pend_d = 1'b0;
               if (flush_req && (word_cnt_q != '0)) begin
                  state_d = S_CR;
               end
            end
         end
         S_HEX: begin
            oTX_VALID = 1'b1;
            oTX_DATA  = hex_char;
            if (iTX_READY) begin
               shift_d = shift_q << 4;
               idx_d   = idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
                  idx_d      = '0;
                  word_cnt_d = cnt_inc;
                  state_d    = ((cnt_inc == LINE_FULL) || flush_req) ? S_CR : S_SEP;
               end
            end
         end
         S_SEP: begin
            oTX_VALID = 1'b1;
            oTX_DATA  = SEP_CHAR;
            if (iTX_READY) begin
               state_d = S_IDLE;
            end
         end
         S_CR: begin
            oTX_VALID = 1'b1;
            oTX_DATA  = 8'h0D;
            if (iTX_READY) begin
               state_d = S_LF;
            end
         end
         S_LF: begin
            oTX_VALID = 1'b1;
            oTX_DATA  = 8'h0A;
            if (iTX_READY) begin
               word_cnt_d   = '0;
               flush_pend_d = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         idx_q        <= '0;
         word_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         idx_q        <= idx_d;
         word_cnt_q   <= word_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign oBUSY     = (state_q != S_IDLE);
   assign oWORD_CNT = word_cnt_q;

endmodule

// File: tb/tb_hex_dump_tx_seq.sv
// Directed self-checking bench for hex_dump_tx_seq: hex digits, separators,
// line wrap, flush handling, Tx back-pressure and mid-word reset.
module tb_hex_dump_tx_seq;

   logic        CLK;
   logic        RST;
   logic [15:0] iDATA;
   logic        iVALID;
   logic        oREADY;
   logic        iFLUSH;
   logic [7:0]  oTX_DATA;
   logic        oTX_VALID;
   logic        iTX_READY;
   logic        oBUSY;
   logic [3:0]  oWORD_CNT;

   int          total = 0;
   int          bad   = 0;
   int          cyc_used;
   logic [7:0]  got_q[$];

   hex_dump_tx_seq #(
      .DATA_WIDTH     (16),
      .WORDS_PER_LINE (8),
      .SEP_CHAR       (8'h20)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .iDATA     (iDATA),
      .iVALID    (iVALID),
      .oREADY    (oREADY),
      .iFLUSH    (iFLUSH),
      .oTX_DATA  (oTX_DATA),
      .oTX_VALID (oTX_VALID),
      .iTX_READY (iTX_READY),
      .oBUSY     (oBUSY),
      .oWORD_CNT (oWORD_CNT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Presents one word for a single IDLE cycle; the handshake happens at the next edge.
   task automatic send_word(input string tag, input logic [15:0] d, input logic fl);
      check({tag, "_ready"}, 32'(oREADY), 32'd1);
      iDATA  = d;
      iVALID = 1'b1;
      iFLUSH = fl;
      step();
      iVALID = 1'b0;
      iFLUSH = 1'b0;
   endtask

   // Collects n handshaken bytes, optionally with random back-pressure and flush
   // pulses on the cycles flagged in fmask, then compares them with exp (MSB byte first).
   task automatic dump(input string tag, input int n, input bit rnd,
                       input logic [15:0] fmask, input logic [63:0] exp);
      logic [7:0] held;
      logic [7:0] b;
      bit         stalled;
      int         k;
      held    = 8'h00;
      stalled = 1'b0;
      k       = 0;
      got_q.delete();
      while ((got_q.size() < n) && (k < 200)) begin
         iFLUSH = (k < 16) ? fmask[k] : 1'b0;
         if (rnd) iTX_READY = 1'($urandom_range(0, 1));
         if (stalled) check({tag, "_hold"}, 32'({oTX_VALID, oTX_DATA}), 32'({1'b1, held}));
         if (oTX_VALID) begin
            if (iTX_READY) begin
               got_q.push_back(oTX_DATA);
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = oTX_DATA;
            end
         end
         step();
         k++;
      end
      iFLUSH    = 1'b0;
      iTX_READY = 1'b1;
      cyc_used  = k;
      check({tag, "_count"}, 32'(got_q.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         b = (i < got_q.size()) ? got_q[i] : 8'h00;
         check($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[8*(n-1-i) +: 8]));
      end
      check({tag, "_idle"}, 32'(oBUSY), 32'd0);
   endtask

   initial begin
      RST       = 1'b1;
      iDATA     = 16'h0000;
      iVALID    = 1'b0;
      iFLUSH    = 1'b0;
      iTX_READY = 1'b1;
      step();
      step();
      check("rst_valid", 32'(oTX_VALID), 32'd0);
      check("rst_data",  32'(oTX_DATA),  32'h00);
      check("rst_cnt",   32'(oWORD_CNT), 32'd0);
      check("rst_busy",  32'(oBUSY),     32'd0);
      RST = 1'b0;
      step();
      check("post_rst_ready", 32'(oREADY), 32'd1);

      // Single mid-line word: five bytes in five consecutive cycles, IDLE after.
      send_word("w1a2f", 16'h1A2F, 1'b0);
      dump("w1a2f", 5, 1'b0, 16'h0000, 64'h0000_0031_4132_4620);
      check("w1a2f_cycles", 32'(cyc_used), 32'd5);
      check("w1a2f_ready",  32'(oREADY),   32'd1);
      check("w1a2f_cnt",    32'(oWORD_CNT), 32'd1);

      // Bring the line to three words, then flush from IDLE.
      send_word("w0", 16'h0000, 1'b0);
      dump("w0", 5, 1'b0, 16'h0000, 64'h0000_0030_3030_3020);
      send_word("w1", 16'h0001, 1'b0);
      dump("w1", 5, 1'b0, 16'h0000, 64'h0000_0030_3030_3120);
      check("cnt3", 32'(oWORD_CNT), 32'd3);
      iFLUSH = 1'b1;
      step();
      iFLUSH = 1'b0;
      dump("idle_flush", 2, 1'b0, 16'h0000, 64'h0000_0000_0000_0D0A);
      check("idle_flush_cnt", 32'(oWORD_CNT), 32'd0);

      // Flush with an empty line produces nothing.
      iFLUSH = 1'b1;
      step();
      iFLUSH = 1'b0;
      check("empty_flush_valid", 32'(oTX_VALID), 32'd0);
      check("empty_flush_busy",  32'(oBUSY),     32'd0);
      step();
      check("empty_flush_valid2", 32'(oTX_VALID), 32'd0);

      // Full line of eight words: last one ends with CR/LF instead of a separator.
      for (int w = 0; w < 7; w++) begin
         send_word("line", 16'(w), 1'b0);
         dump("line", 5, 1'b0, 16'h0000, {24'h0, 8'h30, 8'h30, 8'h30, 8'(8'h30 + w), 8'h20});
      end
      check("line_cnt7", 32'(oWORD_CNT), 32'd7);
      send_word("line8", 16'h0007, 1'b0);
      dump("line8", 6, 1'b0, 16'h0000, 64'h0000_3030_3037_0D0A);
      check("line8_cnt", 32'(oWORD_CNT), 32'd0);
      send_word("line9", 16'h0008, 1'b0);
      dump("line9", 5, 1'b0, 16'h0000, 64'h0000_0030_3030_3820);
      check("line9_cnt", 32'(oWORD_CNT), 32'd1);

      // Random back-pressure: bytes held stable, none lost or repeated.
      send_word("beef", 16'hBEEF, 1'b0);
      dump("beef", 5, 1'b1, 16'h0000, 64'h0000_0042_4545_4620);
      check("beef_cnt", 32'(oWORD_CNT), 32'd2);

      // Two flush pulses mid-word merge into one CR/LF replacing the separator.
      send_word("dflush", 16'h1234, 1'b0);
      dump("dflush", 6, 1'b0, 16'h0006, 64'h0000_3132_3334_0D0A);
      check("dflush_cnt", 32'(oWORD_CNT), 32'd0);

      // Flush together with the word, plus a stray pulse during CR.
      send_word("simul", 16'h00FF, 1'b1);
      dump("simul", 6, 1'b0, 16'h0010, 64'h0000_3030_4646_0D0A);
      check("simul_cnt", 32'(oWORD_CNT), 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("simul_no_extra", 32'(oTX_VALID), 32'd0);
         step();
      end

      // A mid-line word must still end with the separator (no stale flush).
      send_word("w9", 16'h0009, 1'b0);
      dump("w9", 5, 1'b0, 16'h0000, 64'h0000_0030_3030_3920);
      check("w9_cnt", 32'(oWORD_CNT), 32'd1);

      // Reset during the second digit discards the word.
      send_word("rstmid", 16'hABCD, 1'b0);
      check("rstmid_d1", 32'(oTX_DATA), 32'h41);
      step();
      check("rstmid_d2", 32'(oTX_DATA), 32'h42);
      RST = 1'b1;
      step();
      check("rstmid_valid", 32'(oTX_VALID), 32'd0);
      check("rstmid_ready", 32'(oREADY),    32'd1);
      check("rstmid_cnt",   32'(oWORD_CNT), 32'd0);
      RST = 1'b0;
      step();
      send_word("after_rst", 16'h5A3C, 1'b0);
      dump("after_rst", 5, 1'b0, 16'h0000, 64'h0000_0035_4133_4320);
      check("after_rst_cnt", 32'(oWORD_CNT), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
